pipe_stage_skid: RTL and testbench

- Generic pipeline-stage register that replaces per-stage latches such as the fetch/decode boundary.
- Carries a parametrised payload with a valid/ready handshake, so stalls are expressed by back-pressure instead of an enable pin.
- Contains a 2-entry skid buffer, so `in_ready` is driven directly from state and never combinationally from `out_ready`. Long stall chains therefore do not create combinational paths.
- Supports a synchronous flush that turns the stage into a bubble, with an all-zero (NOP) payload.

---
 rtl/pipe_stage_skid.sv | 109 ++++++++++
 tb/tb_pipe_stage_skid.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with 2-entry skid buffer and flush
module pipe_stage_skid #(
   parameter int                 DATA_W    = 64,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   // EMPTY: nothing held; ONE: main_q live; FULL: main_q and skid_q live (skid_q is younger)
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } st_t;

   st_t               st;
   st_t               st_next;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_q;
   logic [DATA_W-1:0] skid_d;
   logic              push;
   logic              pop;

   // Handshake outputs come from registered state only, so in_ready never sees out_ready
   assign out_valid = (st != ST_EMPTY);
   assign in_ready  = (st != ST_FULL);
   assign out_data  = main_q;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Occupancy count decoded from state
   always_comb begin
      count = 2'd0;
      case (st)
         ST_EMPTY: count = 2'd0;
         ST_ONE:   count = 2'd1;
         ST_FULL:  count = 2'd2;
         default:  count = 2'd0;
      endcase
   end

   // State and payload registers; reset forces the NOP payload immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st     <= ST_EMPTY;
         main_q <= RESET_VAL;
         skid_q <= RESET_VAL;
      end else begin
         st     <= st_next;
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   // Next-state and next-payload; flush wins over push and pop and empties both slots
   always_comb begin
      st_next = st;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         st_next = ST_EMPTY;
         main_d  = RESET_VAL;
         skid_d  = RESET_VAL;
      end else begin
         case (st)
            ST_EMPTY: begin
               if (push) begin
                  st_next = ST_ONE;
                  main_d  = in_data;
               end
            end
            ST_ONE: begin
               if (push && pop) begin
                  main_d = in_data;
               end else if (push) begin
                  st_next = ST_FULL;
                  skid_d  = in_data;
               end else if (pop) begin
                  st_next = ST_EMPTY;
                  main_d  = RESET_VAL;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  st_next = ST_ONE;
                  main_d  = skid_q;
                  skid_d  = RESET_VAL;
               end
            end
            default: begin
               st_next = ST_EMPTY;
               main_d  = RESET_VAL;
               skid_d  = RESET_VAL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         fl;
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         e_ov;
      logic         e_ir;
      logic [1:0]   e_cnt;
      logic [W-1:0] e_od;
      string        name;
   } vec_t;

   vec_t vecs[$];

   pipe_stage_skid #(.DATA_W(W), .RESET_VAL('0)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic ov, input logic ir, input logic [1:0] cnt,
                          input logic [W-1:0] od);
      chk({name, ".out_valid"}, 32'(out_valid), 32'(ov));
      chk({name, ".in_ready"}, 32'(in_ready), 32'(ir));
      chk({name, ".count"}, 32'(count), 32'(cnt));
      chk({name, ".out_data"}, 32'(out_data), 32'(od));
   endtask

   task automatic addv(input string name, input logic fl, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic ov, input logic ir, input logic [1:0] cnt,
                       input logic [W-1:0] od);
      vec_t v;
      v.name = name; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
      v.e_ov = ov; v.e_ir = ir; v.e_cnt = cnt; v.e_od = od;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [W-1:0] id, input logic ordy);
      flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
   endtask

   initial begin
      logic [W-1:0] q[$];
      logic         m_ir;

      // name, flush, in_valid, in_data, out_ready | out_valid, in_ready, count, out_data (after edge)
      addv("stream1",   0, 1, 16'h1, 1, 1, 1, 1, 16'h1);
      addv("stream2",   0, 1, 16'h2, 1, 1, 1, 1, 16'h2);
      addv("stream3",   0, 1, 16'h3, 1, 1, 1, 1, 16'h3);
      addv("stream4",   0, 1, 16'h4, 1, 1, 1, 1, 16'h4);
      addv("drain",     0, 0, 16'h0, 1, 0, 1, 0, 16'h0);
      addv("rdy_empty", 0, 0, 16'h0, 1, 0, 1, 0, 16'h0);
      addv("stall5",    0, 1, 16'h5, 0, 1, 1, 1, 16'h5);
      addv("stall6",    0, 1, 16'h6, 0, 1, 0, 2, 16'h5);
      addv("offer7",    0, 1, 16'h7, 0, 1, 0, 2, 16'h5);
      addv("pop5",      0, 1, 16'h7, 1, 1, 1, 1, 16'h6);
      addv("pop6push7", 0, 1, 16'h7, 1, 1, 1, 1, 16'h7);
      addv("pop7",      0, 0, 16'h0, 1, 0, 1, 0, 16'h0);
      addv("fill5",     0, 1, 16'h5, 0, 1, 1, 1, 16'h5);
      addv("fill6",     0, 1, 16'h6, 0, 1, 0, 2, 16'h5);
      addv("flushfull", 1, 1, 16'h9, 1, 0, 1, 0, 16'h0);
      addv("postflush", 0, 0, 16'h0, 1, 0, 1, 0, 16'h0);
      addv("hold3",     0, 1, 16'h3, 0, 1, 1, 1, 16'h3);
      addv("pushpop8",  0, 1, 16'h8, 1, 1, 1, 1, 16'h8);
      addv("idle8",     0, 0, 16'h0, 0, 1, 1, 1, 16'h8);
      addv("flushone",  1, 0, 16'h0, 0, 0, 1, 0, 16'h0);
      addv("flushpush", 1, 1, 16'hB, 0, 0, 1, 0, 16'h0);

      reset = 1'b0;
      drive(0, 0, '0, 0);
      #1;
      chk_all("reset", 0, 1, 0, 16'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
         @(posedge clk);
         #1;
         chk_all(vecs[i].name, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_cnt, vecs[i].e_od);
      end

      // Asynchronous reset in the middle of a full stage
      @(negedge clk); drive(0, 1, 16'h5, 0);
      @(negedge clk); drive(0, 1, 16'h6, 0);
      @(negedge clk); drive(0, 1, 16'h7, 0);
      #2;
      chk("prereset.count", 32'(count), 32'd2);
      reset = 1'b0;
      #1;
      chk_all("async_reset", 0, 1, 0, 16'h0);
      @(negedge clk);
      chk_all("in_reset", 0, 1, 0, 16'h0);
      #1 reset = 1'b1;
      drive(0, 1, 16'hA, 0);
      @(posedge clk);
      #1;
      chk_all("first_push", 1, 1, 1, 16'hA);
      @(negedge clk);
      drive(0, 0, '0, 0);
      reset = 1'b0;
      #1 reset = 1'b1;
      chk_all("reset2", 0, 1, 0, 16'h0);

      // Random traffic against a queue model
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         m_ir = (q.size() < 2);
         chk("rnd.in_ready", 32'(in_ready), 32'(m_ir));
         chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
         chk("rnd.count", 32'(count), 32'(q.size()));
         chk("rnd.out_data", 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
         drive(($urandom_range(0, 99) < 5), 1'($urandom), W'($urandom), 1'($urandom));
         #1;
         chk("rnd.in_ready_indep", 32'(in_ready), 32'(m_ir));
         if (flush) begin
            q.delete();
         end else begin
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && m_ir) q.push_back(in_data);
         end
         @(posedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
